// File: rtl/mmcm_drp_pkg.sv
// Shared types and constants for the MMCM DRP divide-change controller.
// The readback states exist only when MMCM_DRP_READBACK_EN is defined.
package mmcm_drp_pkg;

  localparam int unsigned DIV_W   = 8;
  localparam int unsigned DRP_AW  = 7;
  localparam int unsigned DRP_DW  = 16;
  localparam int unsigned FIELD_W = 6;

  localparam logic [DRP_AW-1:0] CLKREG1_ADDR = 7'h08;
  localparam logic [DRP_AW-1:0] CLKREG2_ADDR = 7'h09;
  localparam logic [DRP_DW-1:0] CLKREG1_KEEP = 16'hF000;
  localparam logic [DRP_DW-1:0] CLKREG2_KEEP = 16'hFF00;

  localparam logic [DIV_W-1:0] DIV_MIN = 8'd2;
  localparam logic [DIV_W-1:0] DIV_MAX = 8'd126;

  typedef enum logic [4:0] {
    IDLE,
    RST_ASSERT,
    RD1,
    WAIT_RD1,
    WR1,
    WAIT_WR1,
    RD2,
    WAIT_RD2,
    WR2,
    WAIT_WR2,
    RST_RELEASE,
    WAIT_LOCK,
    DONE
`ifdef MMCM_DRP_READBACK_EN
    ,
    RB1,
    WAIT_RB1,
    RB2,
    WAIT_RB2
`endif
  } state_e;

  typedef struct packed {
    logic [FIELD_W-1:0] high;
    logic [FIELD_W-1:0] low;
    logic               edge_bit;
  } div_fields_t;

  // ClkReg1: keep [15:12], HIGH_TIME in [11:6], LOW_TIME in [5:0]
  function automatic logic [DRP_DW-1:0] clkreg1_word(input logic [DRP_DW-1:0] rd,
                                                     input div_fields_t f);
    return (rd & CLKREG1_KEEP) | {4'h0, f.high, f.low};
  endfunction

  // ClkReg2: keep [15:8], EDGE in [7], NO_COUNT (always 0) in [6]
  function automatic logic [DRP_DW-1:0] clkreg2_word(input logic [DRP_DW-1:0] rd,
                                                     input div_fields_t f);
    return (rd & CLKREG2_KEEP) | {8'h00, f.edge_bit, 1'b0, 6'h00};
  endfunction

endpackage

// File: rtl/mmcm_drp_ctrl_if.sv
// MMCM dynamic reconfiguration port bundle; master = controller, slave = MMCM.
interface mmcm_drp_ctrl_if;
  import mmcm_drp_pkg::*;

  logic [DRP_AW-1:0] drp_daddr;
  logic              drp_den;
  logic              drp_dwe;
  logic [DRP_DW-1:0] drp_di;
  logic [DRP_DW-1:0] drp_do;
  logic              drp_drdy;

  modport master (
    output drp_daddr, drp_den, drp_dwe, drp_di,
    input  drp_do, drp_drdy
  );

  modport slave (
    input  drp_daddr, drp_den, drp_dwe, drp_di,
    output drp_do, drp_drdy
  );

endinterface

// File: rtl/mmcm_div_calc.sv
// Splits an integer divide into MMCM high/low/edge counter fields and range-checks it.
module mmcm_div_calc
  import mmcm_drp_pkg::*;
(
  input  logic [DIV_W-1:0]   req_div,
  output logic [FIELD_W-1:0] high_c,
  output logic [FIELD_W-1:0] low_c,
  output logic               edge_c,
  output logic               valid_c
);

  logic [DIV_W-1:0] half;

  // Fields are only meaningful when valid_c; truncation for out-of-range values is harmless
  always_comb begin
    half    = req_div >> 1;
    high_c  = FIELD_W'(half);
    low_c   = FIELD_W'(req_div - half);
    edge_c  = req_div[0];
    valid_c = (req_div >= DIV_MIN) && (req_div <= DIV_MAX);
  end

endmodule

// File: rtl/mmcm_drp_ctrl.sv
// Reprograms MMCM CLKOUT0 divide via DRP read-modify-write under MMCM reset, then waits for lock.
// Define MMCM_DRP_READBACK_EN to verify each DRP write with a readback of the same register.
module mmcm_drp_ctrl
  import mmcm_drp_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned DEFAULT_DIV  = 25
) (
  input  logic              clk_in1,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DIV_W-1:0]  req_div,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DIV_W-1:0]  cur_div,
  output logic              mmcm_rst,
  input  logic              mmcm_locked,
  mmcm_drp_ctrl_if.master   drp
);

  localparam int unsigned LOCK_CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(LOCK_TIMEOUT - 1);

  state_e              state_q, state_d;
  div_fields_t         calc_fields, fields_q;
  logic                div_ok, accept;
  logic [DIV_W-1:0]    div_q;
  logic [LOCK_CNT_W-1:0] lock_cnt;
  logic                err_pend, err_pend_d, err_set;
  logic                ready_d, busy_d, done_d, err_d, mmcm_rst_d;
  logic                den_d, dwe_d, den_q, dwe_q;
  logic [DRP_AW-1:0]   daddr_d, daddr_q;
  logic [DRP_DW-1:0]   di_d, di_q;
`ifdef MMCM_DRP_READBACK_EN
  logic [DRP_DW-1:0]   wr_q;
`endif

  mmcm_div_calc u_div_calc (
    .req_div (req_div),
    .high_c  (calc_fields.high),
    .low_c   (calc_fields.low),
    .edge_c  (calc_fields.edge_bit),
    .valid_c (div_ok)
  );

  assign accept = (state_q == IDLE) && req_valid && req_ready;
  assign drp.drp_den   = den_q;
  assign drp.drp_dwe   = dwe_q;
  assign drp.drp_daddr = daddr_q;
  assign drp.drp_di    = di_q;

  always_ff @(posedge clk_in1) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (accept) state_d = div_ok ? RST_ASSERT : DONE;
      RST_ASSERT:  state_d = RD1;
      RD1:         state_d = WAIT_RD1;
      WAIT_RD1:    if (drp.drp_drdy) state_d = WR1;
      WR1:         state_d = WAIT_WR1;
`ifdef MMCM_DRP_READBACK_EN
      WAIT_WR1:    if (drp.drp_drdy) state_d = RB1;
      RB1:         state_d = WAIT_RB1;
      WAIT_RB1:    if (drp.drp_drdy) state_d = RD2;
      WAIT_WR2:    if (drp.drp_drdy) state_d = RB2;
      RB2:         state_d = WAIT_RB2;
      WAIT_RB2:    if (drp.drp_drdy) state_d = RST_RELEASE;
`else
      WAIT_WR1:    if (drp.drp_drdy) state_d = RD2;
      WAIT_WR2:    if (drp.drp_drdy) state_d = RST_RELEASE;
`endif
      RD2:         state_d = WAIT_RD2;
      WAIT_RD2:    if (drp.drp_drdy) state_d = WR2;
      WR2:         state_d = WAIT_WR2;
      RST_RELEASE: state_d = WAIT_LOCK;
      WAIT_LOCK:   if (mmcm_locked || (lock_cnt >= LOCK_LAST)) state_d = DONE;
      DONE:        state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs; write data merges the read data arriving with drdy
  always_comb begin
    ready_d    = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    mmcm_rst_d = !(state_d inside {IDLE, RST_RELEASE, WAIT_LOCK, DONE});
    den_d      = 1'b0;
    dwe_d      = 1'b0;
    daddr_d    = '0;
    di_d       = '0;
    case (state_d)
      RD1: begin den_d = 1'b1; daddr_d = CLKREG1_ADDR; end
      RD2: begin den_d = 1'b1; daddr_d = CLKREG2_ADDR; end
`ifdef MMCM_DRP_READBACK_EN
      RB1: begin den_d = 1'b1; daddr_d = CLKREG1_ADDR; end
      RB2: begin den_d = 1'b1; daddr_d = CLKREG2_ADDR; end
`endif
      WR1: begin
        den_d = 1'b1; dwe_d = 1'b1; daddr_d = CLKREG1_ADDR;
        di_d  = clkreg1_word(drp.drp_do, fields_q);
      end
      WR2: begin
        den_d = 1'b1; dwe_d = 1'b1; daddr_d = CLKREG2_ADDR;
        di_d  = clkreg2_word(drp.drp_do, fields_q);
      end
      default: ;
    endcase

    err_set = 1'b0;
    case (state_q)
      IDLE:      err_set = accept && !div_ok;
      WAIT_LOCK: err_set = !mmcm_locked && (lock_cnt >= LOCK_LAST);
`ifdef MMCM_DRP_READBACK_EN
      WAIT_RB1,
      WAIT_RB2:  err_set = drp.drp_drdy && (drp.drp_do != wr_q);
`endif
      default:   err_set = 1'b0;
    endcase
    err_pend_d = (state_q == IDLE) ? err_set : (err_pend | err_set);
    err_d      = done_d && err_pend_d;
  end

  always_ff @(posedge clk_in1) begin
    if (reset) begin
      req_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mmcm_rst  <= 1'b1;
      cur_div   <= DIV_W'(DEFAULT_DIV);
      den_q     <= 1'b0;
      dwe_q     <= 1'b0;
      daddr_q   <= '0;
      di_q      <= '0;
      err_pend  <= 1'b0;
      lock_cnt  <= '0;
      div_q     <= '0;
      fields_q  <= '0;
`ifdef MMCM_DRP_READBACK_EN
      wr_q      <= '0;
`endif
    end else begin
      req_ready <= ready_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      mmcm_rst  <= mmcm_rst_d;
      den_q     <= den_d;
      dwe_q     <= dwe_d;
      daddr_q   <= daddr_d;
      di_q      <= di_d;
      err_pend  <= err_pend_d;
      if (accept) begin
        div_q    <= req_div;
        fields_q <= calc_fields;
      end
      // Counts cycles since MMCM reset release
      if (state_d == RST_RELEASE) lock_cnt <= '0;
      else if (state_q inside {RST_RELEASE, WAIT_LOCK}) lock_cnt <= lock_cnt + LOCK_CNT_W'(1);
      if ((state_q == WAIT_LOCK) && (state_d == DONE)) cur_div <= div_q;
`ifdef MMCM_DRP_READBACK_EN
      if (dwe_d) wr_q <= di_d;
`endif
    end
  end

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// Directed bench for mmcm_drp_ctrl with a zero-wait DRP register model.
// Honours MMCM_DRP_READBACK_EN for expected latency and the readback-corruption case.
module tb_mmcm_drp_ctrl;
  import mmcm_drp_pkg::*;

  localparam int unsigned LOCK_TO = 16;
`ifdef MMCM_DRP_READBACK_EN
  localparam int NOM_LAT = 16;
  localparam int NOM_DEN = 6;
`else
  localparam int NOM_LAT = 12;
  localparam int NOM_DEN = 4;
`endif

  logic       clk_in1 = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_div = 8'h00;
  logic       mmcm_locked = 1'b1;
  logic       req_ready, busy, done, err, mmcm_rst;
  logic [7:0] cur_div;

  mmcm_drp_ctrl_if drp ();

  mmcm_drp_ctrl #(.LOCK_TIMEOUT(LOCK_TO), .DEFAULT_DIV(25)) dut (
    .clk_in1     (clk_in1),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_div     (req_div),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .cur_div     (cur_div),
    .mmcm_rst    (mmcm_rst),
    .mmcm_locked (mmcm_locked),
    .drp         (drp)
  );

  always #5 clk_in1 = ~clk_in1;

  // DRP register model: answers every den with drdy one cycle later
  logic [15:0] preset1 = '0, preset2 = '0;
  logic        model_load = 1'b0, corrupt2 = 1'b0, stray_drdy = 1'b0;
  logic [15:0] mem1 = '0, mem2 = '0, m_do = '0, wr1_log = '0, wr2_log = '0;
  logic        m_drdy = 1'b0, wr2_seen = 1'b0;
  int          den_cnt = 0, wr_cnt = 0, bad_addr = 0;

  assign drp.drp_do   = m_do;
  assign drp.drp_drdy = m_drdy | stray_drdy;

  always @(posedge clk_in1) begin
    m_drdy <= 1'b0;
    if (model_load) begin
      mem1 <= preset1; mem2 <= preset2;
      wr1_log <= '0; wr2_log <= '0;
      den_cnt <= 0; wr_cnt <= 0; bad_addr <= 0; wr2_seen <= 1'b0;
    end else if (drp.drp_den === 1'b1) begin
      den_cnt <= den_cnt + 1;
      m_drdy  <= 1'b1;
      if (drp.drp_daddr != CLKREG1_ADDR && drp.drp_daddr != CLKREG2_ADDR) bad_addr <= bad_addr + 1;
      if (drp.drp_dwe) begin
        wr_cnt <= wr_cnt + 1;
        if (drp.drp_daddr == CLKREG1_ADDR) begin mem1 <= drp.drp_di; wr1_log <= drp.drp_di; end
        else begin mem2 <= drp.drp_di; wr2_log <= drp.drp_di; wr2_seen <= 1'b1; end
      end else begin
        if (drp.drp_daddr == CLKREG1_ADDR) m_do <= mem1;
        else m_do <= mem2 ^ ((corrupt2 && wr2_seen) ? 16'h0001 : 16'h0000);
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request; latency counts negedges from the cycle after acceptance to done
  task automatic run_txn(input logic [7:0] div, input logic [15:0] r1, input logic [15:0] r2,
                         output int lat, output logic err_at_done, output logic rst_seen,
                         output int rel_cyc);
    @(negedge clk_in1);
    preset1 = r1; preset2 = r2; model_load = 1'b1;
    @(negedge clk_in1);
    model_load = 1'b0; req_valid = 1'b1; req_div = div;
    @(negedge clk_in1);
    req_valid = 1'b0; req_div = 8'hFF;
    lat = 1; rst_seen = 1'b0; rel_cyc = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (mmcm_rst === 1'b1) rst_seen = 1'b1;
      else if (rst_seen && rel_cyc == 0) rel_cyc = lat;
      @(negedge clk_in1);
      lat++;
    end
    err_at_done = err;
  endtask

  typedef struct {
    logic [7:0]  div;
    logic [15:0] r1, r2, w1, w2;
    logic        in_range;
    logic        exp_err;
    logic [7:0]  exp_cur;
  } vec_t;

  vec_t vecs[8];
  int   lat, rel;
  logic e_done, rs_seen;
  int   hits;

  initial begin : main
    vecs[0] = '{8'd25,  16'hF0FF, 16'hABFF, 16'hF30D, 16'hAB80, 1'b1, 1'b0, 8'd25};
    vecs[1] = '{8'd40,  16'hF0FF, 16'hABFF, 16'hF514, 16'hAB00, 1'b1, 1'b0, 8'd40};
    vecs[2] = '{8'd1,   16'hF0FF, 16'hABFF, 16'h0000, 16'h0000, 1'b0, 1'b1, 8'd40};
    vecs[3] = '{8'd127, 16'hF0FF, 16'hABFF, 16'h0000, 16'h0000, 1'b0, 1'b1, 8'd40};
    vecs[4] = '{8'd3,   16'h0000, 16'h00FF, 16'h0042, 16'h0080, 1'b1, 1'b0, 8'd3};
    vecs[5] = '{8'd126, 16'h5A5A, 16'h1234, 16'h5FFF, 16'h1200, 1'b1, 1'b0, 8'd126};
    vecs[6] = '{8'd0,   16'h5A5A, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b1, 8'd126};
    vecs[7] = '{8'd2,   16'hFFFF, 16'hFFFF, 16'hF041, 16'hFF00, 1'b1, 1'b0, 8'd2};

    repeat (3) @(negedge clk_in1);
    check("rst_mmcm_rst", 32'(mmcm_rst), 32'd1);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    check("rst_drp", {drp.drp_den, drp.drp_dwe, drp.drp_daddr, drp.drp_di}, 32'd0);
    check("rst_cur_div", 32'(cur_div), 32'd25);
    reset = 1'b0;
    @(negedge clk_in1);
    check("post_rst_mmcm_rst", 32'(mmcm_rst), 32'd0);
    @(negedge clk_in1);
    check("idle_ready", 32'(req_ready), 32'd1);

    // Stray drdy in IDLE must not move the FSM
    stray_drdy = 1'b1;
    @(negedge clk_in1);
    stray_drdy = 1'b0;
    hits = 0;
    repeat (3) begin
      @(negedge clk_in1);
      if (busy !== 1'b0 || done !== 1'b0) hits++;
    end
    check("stray_drdy_ignored", 32'(hits), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].div, vecs[i].r1, vecs[i].r2, lat, e_done, rs_seen, rel);
      check($sformatf("v%0d_latency", i), 32'(lat), vecs[i].in_range ? 32'(NOM_LAT) : 32'd1);
      check($sformatf("v%0d_err", i), 32'(e_done), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_mmcm_rst_used", i), 32'(rs_seen), 32'(vecs[i].in_range));
      check($sformatf("v%0d_den_count", i), 32'(den_cnt), vecs[i].in_range ? 32'(NOM_DEN) : 32'd0);
      check($sformatf("v%0d_wr_count", i), 32'(wr_cnt), vecs[i].in_range ? 32'd2 : 32'd0);
      check($sformatf("v%0d_bad_addr", i), 32'(bad_addr), 32'd0);
      if (vecs[i].in_range) begin
        check($sformatf("v%0d_clkreg1", i), 32'(wr1_log), 32'(vecs[i].w1));
        check($sformatf("v%0d_clkreg2", i), 32'(wr2_log), 32'(vecs[i].w2));
        check($sformatf("v%0d_release_cycle", i), 32'(rel), 32'(NOM_LAT - 2));
      end
      @(negedge clk_in1);
      check($sformatf("v%0d_done_one_cycle", i), {30'd0, done, err}, 32'd0);
      check($sformatf("v%0d_idle", i), {30'd0, busy, req_ready}, 32'd1);
      check($sformatf("v%0d_cur_div", i), 32'(cur_div), 32'(vecs[i].exp_cur));
    end

    // Lock never arrives: timeout 16 cycles after reset release, cur_div still updated
    mmcm_locked = 1'b0;
    run_txn(8'd25, 16'hF0FF, 16'hABFF, lat, e_done, rs_seen, rel);
    check("to_release_cycle", 32'(rel), 32'(NOM_LAT - 2));
    check("to_latency", 32'(lat), 32'(NOM_LAT - 2 + 16));
    check("to_err", 32'(e_done), 32'd1);
    @(negedge clk_in1);
    check("to_cur_div", 32'(cur_div), 32'd25);
    mmcm_locked = 1'b1;

    // Reset while waiting for the ClkReg1 write acknowledge
    @(negedge clk_in1);
    preset1 = 16'hF0FF; preset2 = 16'hABFF; model_load = 1'b1;
    @(negedge clk_in1);
    model_load = 1'b0; req_valid = 1'b1; req_div = 8'd40;
    @(negedge clk_in1);
    req_valid = 1'b0;
    repeat (4) @(negedge clk_in1);
    check("mid_in_wait_wr1", {29'd0, busy, mmcm_rst, drp.drp_den}, 32'b110);
    reset = 1'b1;
    @(negedge clk_in1);
    check("mid_rst_idle", {28'd0, busy, done, drp.drp_den, req_ready}, 32'd0);
    check("mid_rst_mmcm_rst", 32'(mmcm_rst), 32'd1);
    check("mid_rst_cur_div", 32'(cur_div), 32'd25);
    reset = 1'b0;
    @(negedge clk_in1);
    check("mid_post_mmcm_rst", 32'(mmcm_rst), 32'd0);
    hits = 0;
    repeat (30) begin
      @(negedge clk_in1);
      if (done !== 1'b0 || drp.drp_den !== 1'b0 || busy !== 1'b0) hits++;
    end
    check("mid_abandoned", 32'(hits), 32'd0);
    check("mid_cur_div_kept", 32'(cur_div), 32'd25);

`ifdef MMCM_DRP_READBACK_EN
    corrupt2 = 1'b1;
    run_txn(8'd40, 16'hF0FF, 16'hABFF, lat, e_done, rs_seen, rel);
    check("rb_latency", 32'(lat), 32'd16);
    check("rb_err", 32'(e_done), 32'd1);
    check("rb_wr_count", 32'(wr_cnt), 32'd2);
    @(negedge clk_in1);
    check("rb_cur_div", 32'(cur_div), 32'd40);
    corrupt2 = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected $finish");
    $fatal(1);
  end

endmodule

// File: doc/mmcm_drp_ctrl.md
MMCM_DRP_CTRL -- requirements
Module: mmcm_drp_ctrl

Interface
REQ-001 Parameter LOCK_TIMEOUT, default 65535: cycles allowed for mmcm_locked to rise after MMCM reset release.
REQ-002 Parameter DEFAULT_DIV, default 25: value of cur_div after reset.
REQ-003 clk_in1  in  1  sole clock, rising edge; DRP clock of the MMCM.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 req_valid  in  1  divide-change request.
REQ-006 req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
REQ-007 req_div  in  8  requested CLKOUT0 integer divide.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse at the end of each accepted request.
REQ-010 err  out  1  one-cycle pulse, coincident with done, on failure.
REQ-011 cur_div  out  8  last divide value written.
REQ-012 mmcm_rst  out  1  drives MMCM RST.
REQ-013 mmcm_locked  in  1  MMCM LOCKED.
REQ-014 drp_daddr  out  7; drp_den  out  1; drp_dwe  out  1; drp_di  out  16; drp_do  in  16; drp_drdy  in  1: MMCM DRP port.

Function
REQ-015 States: IDLE, RST_ASSERT, RD1, WAIT_RD1, WR1, WAIT_WR1, RD2, WAIT_RD2, WR2, WAIT_WR2, RST_RELEASE, WAIT_LOCK, DONE.
REQ-016 Valid divide range is 2..126. An out-of-range request is accepted, goes straight to DONE, pulses done and err, and leaves the MMCM and cur_div untouched.
REQ-017 Field values: high = req_div>>1; low = req_div - high; edge = req_div[0]; no_count = 0.
REQ-018 Register contents:
- ClkReg1, address 7'h08: bits [15:12] preserved from the read; [11:6] = high; [5:0] = low.
- ClkReg2, address 7'h09: bits [15:8] preserved; [7] = edge; [6] = no_count; [5:0] = 0.
REQ-019 Accepted divide is latched on acceptance; req_div changes afterwards have no effect.
REQ-020 RST_ASSERT: mmcm_rst goes high, and stays high through WAIT_WR2.
REQ-021 Rd/Wr states: drp_den (and drp_dwe for writes) is a single-cycle pulse with drp_daddr and drp_di valid in the same cycle. WAIT_* states hold until drp_drdy, with no timeout. All DRP outputs are 0 outside pulse cycles.
REQ-022 drp_drdy arriving while not in a WAIT_* state is ignored.
REQ-023 RST_RELEASE: mmcm_rst goes low, and the lock counter clears.
REQ-024 WAIT_LOCK: move to DONE on mmcm_locked == 1. If the counter reaches LOCK_TIMEOUT first, move to DONE with err set.
REQ-025 DONE lasts one cycle: done pulses, cur_div takes the latched divide (including on lock timeout), then return to IDLE.
REQ-026 Latency with zero-wait DRP (drdy the cycle after den) and immediate lock: 12 cycles from acceptance to done.

Reset
REQ-027 On reset, in any state:
- state = IDLE;
- mmcm_rst = 1 while reset is high, 0 on the first cycle after;
- den, dwe, done, err, busy = 0; daddr, di = 0;
- cur_div = DEFAULT_DIV; req_ready = 0 while reset is high.
REQ-028 Reset mid-transaction abandons the transaction with no done pulse.

Configuration
REQ-029 With MMCM_DRP_READBACK_EN defined, each write is followed by a read of the same address. If the read data differs from the written value, err is flagged at DONE but the sequence still completes. Latency grows by 4 cycles.
REQ-030 Without the macro, no readback states exist.

Structure
REQ-031 Package mmcm_drp_pkg holds:
- the state enum;
- the ClkReg1/ClkReg2 addresses;
- the preserve masks 16'hF000 and 16'hFF00;
- the divide range limits 2 and 126.
REQ-032 Sub-module mmcm_div_calc: combinational; takes req_div and outputs high, low, edge and the range-valid flag.

Verification
REQ-033 req_div=25, DRP model reads ClkReg1=16'hF0FF, ClkReg2=16'hABFF -> writes 08:16'hF30D and 09:16'hAB80; done after 12 cycles; cur_div=25; err=0.
REQ-034 req_div=40, same read data -> writes 08:16'hF514 and 09:16'hAB00; cur_div=40.
REQ-035 req_div=1, then req_div=127 -> no DRP activity, mmcm_rst stays low, done and err pulse, cur_div unchanged.
REQ-036 LOCK_TIMEOUT=16, mmcm_locked held at 0 -> done and err pulse 16 cycles after RST_RELEASE; cur_div updated.
REQ-037 Reset asserted in WAIT_WR1 -> next cycle: IDLE, den=0, no done; mmcm_rst low one cycle after reset deasserts; cur_div=25.
REQ-038 With MMCM_DRP_READBACK_EN, model corrupts the ClkReg2 readback -> err with done; latency 16 cycles.
